issue_select: RTL

ISSUE_SELECT -- requirements
Module: issue_select

---
 rtl/issue_select_if.sv | 31 +++
 rtl/issue_select.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/issue_select_if.sv
// Issue-select port bundle: issue-queue window, pops, writebacks and the two execute ports.
interface issue_select_if #(
  parameter int unsigned ENTRY_W = 20,
  parameter int unsigned IDX_W   = 3
);
  logic                     flush;
  logic                     vld0, vld1, vld2, vld3;
  logic [ENTRY_W-1:0]       data0, data1, data2, data3;
  logic [IDX_W-1:0]         index0, index1, index2, index3;
  logic                     pop0, pop1;
  logic [IDX_W-1:0]         pop_key0, pop_key1;
  logic                     wb0, wb1;
  logic [4:0]               wb_rd0, wb_rd1;
  logic                     ex_ready0, ex_ready1;
  logic                     ex_vld0, ex_vld1;
  logic [ENTRY_W+IDX_W-1:0] ex_data0, ex_data1;

  modport slave (
    input  flush, vld0, vld1, vld2, vld3, data0, data1, data2, data3,
           index0, index1, index2, index3, wb0, wb1, wb_rd0, wb_rd1,
           ex_ready0, ex_ready1,
    output pop0, pop1, pop_key0, pop_key1, ex_vld0, ex_vld1, ex_data0, ex_data1
  );

  modport master (
    output flush, vld0, vld1, vld2, vld3, data0, data1, data2, data3,
           index0, index1, index2, index3, wb0, wb1, wb_rd0, wb_rd1,
           ex_ready0, ex_ready1,
    input  pop0, pop1, pop_key0, pop_key1, ex_vld0, ex_vld1, ex_data0, ex_data1
  );
endinterface

// File: rtl/issue_select.sv
// Dual-issue selector: scoreboarded oldest-first pick from a 4-entry window into two issue registers.
module issue_select #(
  parameter int unsigned ENTRY_W = 20,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned RS_LO   = 10,
  parameter int unsigned RT_LO   = 5,
  parameter int unsigned RD_LO   = 0
) (
  input logic          clk,
  input logic          reset,
  issue_select_if.slave bus
);
  localparam int unsigned PAY_W = ENTRY_W + IDX_W;

  logic [3:0]         w_vld;
  logic [ENTRY_W-1:0] w_data  [4];
  logic [IDX_W-1:0]   w_index [4];
  logic [4:0]         w_rs [4];
  logic [4:0]         w_rt [4];
  logic [4:0]         w_rd [4];
  logic [31:0]        r_busy, w_wb_dec, w_eff_busy, w_set_dec, w_busy_nxt;
  logic [3:0]         w_ready;
  logic               w_first_v, w_second_v;
  logic [1:0]         w_first, w_second;
  logic               w_open0, w_open1, w_iss0, w_iss1;
  logic [1:0]         w_key0, w_key1;
  logic               r_vld0, r_vld1;
  logic [PAY_W-1:0]   r_data0, r_data1;

  always_comb begin
    w_vld      = {bus.vld3, bus.vld2, bus.vld1, bus.vld0};
    w_data[0]  = bus.data0;  w_data[1]  = bus.data1;
    w_data[2]  = bus.data2;  w_data[3]  = bus.data3;
    w_index[0] = bus.index0; w_index[1] = bus.index1;
    w_index[2] = bus.index2; w_index[3] = bus.index3;
    for (int unsigned j = 0; j < 4; j++) begin
      w_rs[j] = w_data[j][RS_LO +: 5];
      w_rt[j] = w_data[j][RT_LO +: 5];
      w_rd[j] = w_data[j][RD_LO +: 5];
    end
  end

  // Same-cycle writebacks wake dependants before the ready check.
  always_comb begin
    w_wb_dec = '0;
    if (bus.wb0) w_wb_dec[bus.wb_rd0] = 1'b1;
    if (bus.wb1) w_wb_dec[bus.wb_rd1] = 1'b1;
    w_eff_busy = r_busy & ~w_wb_dec;
  end

  // Any older valid writer blocks j; if that writer issues now, the pair check would drop j anyway.
  always_comb begin
    for (int unsigned j = 0; j < 4; j++) begin
      w_ready[j] = w_vld[j] && !w_eff_busy[w_rs[j]] && !w_eff_busy[w_rt[j]]
                   && !w_eff_busy[w_rd[j]];
      for (int unsigned i = 0; i < j; i++) begin
        if (w_vld[i] && (w_rd[i] != 5'd0) &&
            ((w_rd[i] == w_rs[j]) || (w_rd[i] == w_rt[j]) || (w_rd[i] == w_rd[j])))
          w_ready[j] = 1'b0;
      end
    end
  end

  always_comb begin
    w_first_v  = 1'b0;
    w_first    = '0;
    w_second_v = 1'b0;
    w_second   = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (w_ready[j] && !w_first_v) begin
        w_first_v = 1'b1;
        w_first   = 2'(j);
      end
    end
    for (int unsigned j = 0; j < 4; j++) begin
      if (w_first_v && w_ready[j] && (2'(j) > w_first) && !w_second_v) begin
        w_second_v = 1'b1;
        w_second   = 2'(j);
      end
    end
    if (w_second_v && (w_rd[w_first] != 5'd0) &&
        ((w_rd[w_first] == w_rs[w_second]) || (w_rd[w_first] == w_rt[w_second]) ||
         (w_rd[w_first] == w_rd[w_second])))
      w_second_v = 1'b0;
  end

  always_comb begin
    w_open0 = !r_vld0 || bus.ex_ready0;
    w_open1 = !r_vld1 || bus.ex_ready1;
    w_iss0  = 1'b0;
    w_iss1  = 1'b0;
    w_key0  = '0;
    w_key1  = '0;
    if (!reset && !bus.flush) begin
      if (w_open0) begin
        w_iss0 = w_first_v;
        w_key0 = w_first_v ? w_first : 2'd0;
        w_iss1 = w_open1 && w_second_v;
        w_key1 = (w_open1 && w_second_v) ? w_second : 2'd0;
      end else if (w_open1) begin
        w_iss1 = w_first_v;
        w_key1 = w_first_v ? w_first : 2'd0;
      end
    end
  end

  // Issue set is applied after writeback clear so a same-rd set wins.
  always_comb begin
    w_set_dec = '0;
    if (w_iss0) w_set_dec[w_rd[w_key0]] = 1'b1;
    if (w_iss1) w_set_dec[w_rd[w_key1]] = 1'b1;
    w_busy_nxt    = w_eff_busy | w_set_dec;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else if (bus.flush) begin
      r_busy <= '0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_iss0) begin
        r_vld0  <= 1'b1;
        r_data0 <= {w_index[w_key0], w_data[w_key0]};
      end else if (bus.ex_ready0) begin
        r_vld0 <= 1'b0;
      end
      if (w_iss1) begin
        r_vld1  <= 1'b1;
        r_data1 <= {w_index[w_key1], w_data[w_key1]};
      end else if (bus.ex_ready1) begin
        r_vld1 <= 1'b0;
      end
    end
  end

  assign bus.pop0     = w_iss0;
  assign bus.pop1     = w_iss1;
  assign bus.pop_key0 = IDX_W'(w_key0);
  assign bus.pop_key1 = IDX_W'(w_key1);
  assign bus.ex_vld0  = r_vld0;
  assign bus.ex_vld1  = r_vld1;
  assign bus.ex_data0 = r_data0;
  assign bus.ex_data1 = r_data1;
endmodule
